cp0_ctrl: RTL
=============

Name: cp0_ctrl

Overview:
Parametrised coprocessor-0 block for the MIPS32 pipeline. It holds the Count, Compare, Status, Cause, EPC and EBase registers and provides MFC0 reads and MTC0 writes. It also handles exception entry, ERET return, a Count/Compare timer interrupt, and interrupt-request generation. It sits beside the MEM/WB stage, and the pipeline flush logic consumes its redirect outputs.

Parameters:
HW_IRQ, 6, number of external hardware interrupt lines (1..6); mapped to Cause.IP[HW_IRQ+1:2]; unused IP bits read 0
COUNT_DIV, 2, Count increments once every COUNT_DIV clocks (1..16)
EBASE_RST, 32'h8000_0000, reset value of EBase
EXC_OFFSET, 32'h0000_0180, offset added to EBase to form the exception vector

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets)
raddr  in  5  MFC0 register number
rdata  out  32  MFC0 read data, combinational
we  in  1  MTC0 write enable
waddr  in  5  MTC0 register number
wdata  in  32  MTC0 data
hw_int  in  HW_IRQ  level-sensitive external interrupts
exc_valid  in  1  exception commit this cycle
exc_code  in  5  ExcCode to record
exc_pc  in  32  PC of faulting instruction
exc_bd  in  1  faulting instruction is in a delay slot
eret  in  1  ERET commit this cycle
irq_req  out  1  interrupt pending and enabled
redirect  out  1  pipeline redirect this cycle
redirect_pc  out  32  target PC for redirect
status_o, cause_o, epc_o  out  32 each  current register values

Behaviour:
- Register map: 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 EBase. Reads of any other address return 0.
- Reset values: Count=0, Compare=0, Status=32'h1000_0000, Cause=0, EPC=0, EBase=EBASE_RST, divider=0, timer pending=0. All outputs are derived from these, so irq_req=0 and redirect=0 during reset.
- rdata reflects the register state before the current edge. A same-cycle write is not forwarded.
- Writable fields:
  - Status: bits 15:8 (IM), 1 (EXL), 0 (IE); the other bits hold their reset value.
  - Cause: only IP[1:0] (bits 9:8).
  - Count, Compare, EPC: full 32 bits.
  - EBase: bits 29:12.
- Cause.IP[HW_IRQ+1:2] is sampled from hw_int every cycle and is not latched.
- Timer:
  - A divider counts 0..COUNT_DIV-1; Count increments when the divider wraps and wraps modulo 2^32.
  - Timer pending (Cause.IP7, Cause.TI bit 30) sets when Count==Compare after an increment.
  - Timer pending clears on any MTC0 write to Compare.
  - A Count write takes effect and resets the divider to 0.
  - If HW_IRQ=6, IP7 = hw_int[5] OR timer pending.
- irq_req = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM).
- Exception entry on exc_valid:
  - EXL<=1 and Cause.ExcCode<=exc_code.
  - If EXL was 0: EPC<=exc_pc-4 and BD<=1 when exc_bd=1; otherwise EPC<=exc_pc and BD<=0.
  - If EXL was already 1 (nested): EPC and BD are unchanged.
  - redirect=1 and redirect_pc=EBase+EXC_OFFSET, combinationally, in the same cycle as exc_valid.
- ERET: EXL<=0, redirect=1, redirect_pc=EPC (pre-edge value).
- Priority in one cycle:
  - exc_valid beats eret; eret is ignored.
  - exc_valid and eret both beat an MTC0 to the same field; the MTC0 is dropped for Status.EXL, Cause.ExcCode/BD and EPC.
  - MTC0 to other fields still applies.
- Count increment and an MTC0 to Count in the same cycle: the write wins.
- Asserting reset mid-operation clears all state immediately. The first edge after rst rises behaves as a normal cycle.

Test Plan:
- Reset with rst=0 -> status_o=32'h1000_0000, read 15 gives 32'h8000_0000, irq_req=0, redirect=0. MTC0 Status 32'h0000_FF01 then read 12 -> 32'h1000_FF01.
- COUNT_DIV=2, Compare<=5 -> Cause bit 30 and IP7 set 10 clocks after the write. With Status=32'h1000_8001, irq_req=1. Writing Compare clears IP7 next cycle.
- Status=32'h1000_0401 and hw_int[0]=1 -> Cause bit 10=1 and irq_req=1. Dropping hw_int gives Cause bit 10=0 the next cycle.
- exc_valid, exc_code=8, exc_pc=32'h8000_0104, exc_bd=1 -> redirect_pc=32'h8000_0180, EPC=32'h8000_0100, Cause bit31=1, Cause[6:2]=8, EXL=1, irq_req=0.
- Second exc_valid while EXL=1 with exc_pc=32'h8000_0200 -> EPC stays 32'h8000_0100 and ExcCode is updated. Then eret -> redirect_pc=32'h8000_0100 and EXL=0.
- Same cycle: exc_valid, eret and MTC0 EPC=32'h1234 -> exception wins, EPC=exc_pc, redirect_pc is the vector. Reset asserted mid-timer-count -> Count=0 immediately.

Source files
------------

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: MIPS32 coprocessor-0 register block.
// Holds Count/Compare/Status/Cause/EPC/EBase, serves MFC0 reads and MTC0
// writes, and handles exception entry, ERET return, the Count/Compare
// timer interrupt and interrupt-request generation.
// Note: rst is active low despite its name.
module cp0_ctrl #(
    parameter int          HW_IRQ     = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] EBASE_RST  = 32'h8000_0000,
    parameter logic [31:0] EXC_OFFSET = 32'h0000_0180
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        raddr,
    output logic [31:0]       rdata,
    input  logic              we,
    input  logic [4:0]        waddr,
    input  logic [31:0]       wdata,
    input  logic [HW_IRQ-1:0] hw_int,
    input  logic              exc_valid,
    input  logic [4:0]        exc_code,
    input  logic [31:0]       exc_pc,
    input  logic              exc_bd,
    input  logic              eret,
    output logic              irq_req,
    output logic              redirect,
    output logic [31:0]       redirect_pc,
    output logic [31:0]       status_o,
    output logic [31:0]       cause_o,
    output logic [31:0]       epc_o
);

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_STATUS  = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;
    localparam logic [4:0] ADDR_EBASE   = 5'd15;

    localparam logic [3:0] DIV_LAST = 4'(COUNT_DIV - 1);

    logic [31:0] count_q,    count_d;
    logic [31:0] compare_q,  compare_d;
    logic [7:0]  im_q,       im_d;
    logic        exl_q,      exl_d;
    logic        ie_q,       ie_d;
    logic [1:0]  swIp_q,     swIp_d;
    logic [5:0]  hwIp_q,     hwIp_d;
    logic        timer_q,    timer_d;
    logic [4:0]  excCode_q,  excCode_d;
    logic        bd_q,       bd_d;
    logic [31:0] epc_q,      epc_d;
    logic [17:0] ebaseMid_q, ebaseMid_d;
    logic [3:0]  div_q,      div_d;

    logic [5:0]  hwPad;
    logic [7:0]  ipVec;
    logic [31:0] statusVal;
    logic [31:0] causeVal;
    logic [31:0] ebaseVal;
    logic [31:0] countInc;
    logic        divWrap;
    logic        trapEvent;
    logic        wrCount;
    logic        wrCompare;
    logic        wrStatus;
    logic        wrCause;
    logic        wrEpc;
    logic        wrEbase;

    // Zero-extend the external interrupt lines to the full six IP slots so
    // that unused IP bits always read 0 regardless of HW_IRQ.
    always_comb begin
        hwPad = '0;
        hwPad[HW_IRQ-1:0] = hw_int;
    end

    // IP7 is shared between the timer and the sixth hardware line; hwIp_q[5]
    // can only be non-zero when HW_IRQ is 6 because of the zero padding.
    assign ipVec     = {timer_q | hwIp_q[5], hwIp_q[4:0], swIp_q};
    assign statusVal = {4'h1, 12'h000, im_q, 6'b000000, exl_q, ie_q};
    assign causeVal  = {bd_q, timer_q, 14'h0000, ipVec, 1'b0, excCode_q, 2'b00};
    assign ebaseVal  = {EBASE_RST[31:30], ebaseMid_q, EBASE_RST[11:0]};

    assign status_o = statusVal;
    assign cause_o  = causeVal;
    assign epc_o    = epc_q;

    assign irq_req = ie_q & ~exl_q & (|(ipVec & im_q));

    // Redirects are qualified by reset so the flush logic sees nothing while
    // the block is held in reset.
    assign redirect    = rst & (exc_valid | eret);
    assign redirect_pc = exc_valid ? (ebaseVal + EXC_OFFSET) : epc_q;

    assign trapEvent = exc_valid | eret;
    assign wrCount   = we && (waddr == ADDR_COUNT);
    assign wrCompare = we && (waddr == ADDR_COMPARE);
    assign wrStatus  = we && (waddr == ADDR_STATUS);
    assign wrCause   = we && (waddr == ADDR_CAUSE);
    assign wrEpc     = we && (waddr == ADDR_EPC);
    assign wrEbase   = we && (waddr == ADDR_EBASE);

    assign divWrap  = (div_q == DIV_LAST);
    assign countInc = count_q + 32'd1;

    // MFC0 read mux; shows pre-edge register state, no write forwarding.
    always_comb begin
        rdata = 32'h0000_0000;
        case (raddr)
            ADDR_COUNT:   rdata = count_q;
            ADDR_COMPARE: rdata = compare_q;
            ADDR_STATUS:  rdata = statusVal;
            ADDR_CAUSE:   rdata = causeVal;
            ADDR_EPC:     rdata = epc_q;
            ADDR_EBASE:   rdata = ebaseVal;
            default:      rdata = 32'h0000_0000;
        endcase
    end

    // Next-state logic: timer first, then MTC0 writes, then trap events so
    // that exception/ERET updates override any conflicting software write.
    always_comb begin
        count_d    = count_q;
        compare_d  = compare_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        swIp_d     = swIp_q;
        hwIp_d     = hwPad;
        timer_d    = timer_q;
        excCode_d  = excCode_q;
        bd_d       = bd_q;
        epc_d      = epc_q;
        ebaseMid_d = ebaseMid_q;
        div_d      = div_q;

        if (divWrap) begin
            div_d   = 4'd0;
            count_d = countInc;
        end else begin
            div_d = div_q + 4'd1;
        end

        if (wrCount) begin
            count_d = wdata;
            div_d   = 4'd0;
        end

        if (wrCompare) begin
            compare_d = wdata;
            timer_d   = 1'b0;
        end else if (divWrap && !wrCount && (countInc == compare_q)) begin
            timer_d = 1'b1;
        end

        if (wrStatus) begin
            im_d = wdata[15:8];
            ie_d = wdata[0];
            if (!trapEvent) begin
                exl_d = wdata[1];
            end
        end

        if (wrCause) begin
            swIp_d = wdata[9:8];
        end

        if (wrEpc && !trapEvent) begin
            epc_d = wdata;
        end

        if (wrEbase) begin
            ebaseMid_d = wdata[29:12];
        end

        if (exc_valid) begin
            exl_d     = 1'b1;
            excCode_d = exc_code;
            if (!exl_q) begin
                bd_d  = exc_bd;
                epc_d = exc_bd ? (exc_pc - 32'd4) : exc_pc;
            end
        end else if (eret) begin
            exl_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= 32'h0000_0000;
            compare_q  <= 32'h0000_0000;
            im_q       <= 8'h00;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            swIp_q     <= 2'b00;
            hwIp_q     <= 6'b000000;
            timer_q    <= 1'b0;
            excCode_q  <= 5'd0;
            bd_q       <= 1'b0;
            epc_q      <= 32'h0000_0000;
            ebaseMid_q <= EBASE_RST[29:12];
            div_q      <= 4'd0;
        end else begin
            count_q    <= count_d;
            compare_q  <= compare_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            swIp_q     <= swIp_d;
            hwIp_q     <= hwIp_d;
            timer_q    <= timer_d;
            excCode_q  <= excCode_d;
            bd_q       <= bd_d;
            epc_q      <= epc_d;
            ebaseMid_q <= ebaseMid_d;
            div_q      <= div_d;
        end
    end

endmodule
